// File: rtl/nibble_add_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_add_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int SLICE_W = 4;

  // Index register width; a single-nibble adder still keeps a 1-bit index.
  function automatic int idx_bits(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_seq_if.sv
// Operand intake / result delivery handshake bundle for nibble_add_seq.
interface nibble_add_seq_if #(
  parameter int WIDTH = 16
);

  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic             done_valid;
  logic             done_ready;
  logic             busy;

  modport master (
    output start_valid, a, b, cin, done_ready,
    input  start_ready, sum, done_valid, busy
  );

  modport slave (
    input  start_valid, a, b, cin, done_ready,
    output start_ready, sum, done_valid, busy
  );

endinterface

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice
  import nibble_add_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[SLICE_W-1:0];
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/nibble_add_seq.sv
// Multi-cycle WIDTH-bit adder: one shared CLA slice stepped LS nibble first,
// inter-nibble carry held in a register, valid/ready on both sides.
module nibble_add_seq
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic             clk,
  input logic             rst,
  nibble_add_seq_if.slave bus
);

  localparam int NIB   = WIDTH / SLICE_W;
  localparam int IDX_W = idx_bits(NIB);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

  if (WIDTH < SLICE_W || (WIDTH % SLICE_W) != 0) begin : g_bad_width
    $error("nibble_add_seq: WIDTH must be a positive multiple of 4");
  end

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               carry_q;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH:0]     sum_q;

  logic [SLICE_W-1:0] s_a;
  logic [SLICE_W-1:0] s_b;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;

  always_comb begin
    s_a = a_q[SLICE_W*idx +: SLICE_W];
    s_b = b_q[SLICE_W*idx +: SLICE_W];
  end

  cla4_slice u_slice (
    .a    (s_a),
    .b    (s_b),
    .cin  (carry_q),
    .sum  (s_sum),
    .cout (s_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            carry_q <= bus.cin;
            idx     <= '0;
            sum_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[SLICE_W*idx +: SLICE_W] <= s_sum;
          carry_q                       <= s_cout;
          if (idx == IDX_LAST) begin
            sum_q[WIDTH] <= s_cout;
            state        <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.done_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags depend on the state register alone.
  assign bus.start_ready = (state == IDLE);
  assign bus.busy        = (state == RUN);
  assign bus.done_valid  = (state == DONE);
  assign bus.sum         = sum_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq: transaction-level model plus
// directed literal vectors, WIDTH=16 main instance and a WIDTH=4 instance.
module tb_nibble_add_seq;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  nibble_add_seq_if #(.WIDTH(W)) bus ();
  nibble_add_seq_if #(.WIDTH(4)) bus4 ();

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  nibble_add_seq #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: accept -> NIB busy cycles -> result until taken.
  bit          m_ready = 1'b1;
  bit          m_done  = 1'b0;
  int          m_left  = 0;
  logic [W:0]  m_sum   = '0;
  logic [W:0]  m_pend  = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ready = 1'b1;
      m_done  = 1'b0;
      m_left  = 0;
      m_sum   = '0;
    end else if (m_ready) begin
      if (bus.start_valid) begin
        m_pend  = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cin);
        m_ready = 1'b0;
        m_left  = NIB;
        m_sum   = '0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_sum  = m_pend;
      end
    end else if (m_done && bus.done_ready) begin
      m_done  = 1'b0;
      m_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("model_start_ready", 64'(bus.start_ready), 64'(m_ready));
    chk("model_busy",        64'(bus.busy),        64'(m_left > 0));
    chk("model_done_valid",  64'(bus.done_valid),  64'(m_done));
    if (m_left == 0) chk("model_sum", 64'(bus.sum), 64'(m_sum));
  end

  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [W:0] exp, input int stall, input bit hold,
                         input logic [W-1:0] na, input logic [W-1:0] nb, input logic nc);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin;
    bus.start_valid = 1'b1;
    bus.done_ready  = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.busy && n < 50);
    chk("accept_edge", 64'(n), 64'd1);
    if (hold) begin
      bus.a = na; bus.b = nb; bus.cin = nc;
    end else begin
      bus.start_valid = 1'b0;
      bus.a = ~a; bus.b = ~b; bus.cin = ~cin;
    end
    n = 0;
    while (!bus.done_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("latency", 64'(n), 64'(NIB));
    chk("result", 64'(bus.sum), 64'(exp));
    repeat (stall) begin
      @(posedge clk); #1;
      chk("hold_sum",         64'(bus.sum),         64'(exp));
      chk("hold_start_ready", 64'(bus.start_ready), 64'd0);
      chk("hold_done_valid",  64'(bus.done_valid),  64'd1);
    end
    bus.done_ready = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    chk("idle_after_hs", 64'(bus.start_ready), 64'd1);
    chk("sum_after_hs",  64'(bus.sum),         64'(exp));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   rexp;

    bus.start_valid  = 1'b0; bus.a  = '0; bus.b  = '0; bus.cin  = 1'b0; bus.done_ready  = 1'b0;
    bus4.start_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0; bus4.done_ready = 1'b0;

    #1;
    chk("rst_start_ready", 64'(bus.start_ready), 64'd1);
    chk("rst_done_valid",  64'(bus.done_valid),  64'd0);
    chk("rst_busy",        64'(bus.busy),        64'd0);
    chk("rst_sum",         64'(bus.sum),         64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_txn(16'h00FF, 16'h0001, 1'b0, 17'h00100, 0, 1'b0, '0, '0, 1'b0);
    run_txn(16'hFFFF, 16'h0001, 1'b0, 17'h10000, 1, 1'b0, '0, '0, 1'b0);
    run_txn(16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF, 0, 1'b0, '0, '0, 1'b0);
    run_txn(16'h0000, 16'h0000, 1'b1, 17'h00001, 0, 1'b0, '0, '0, 1'b0);

    // Backpressure with new operands presented throughout DONE.
    run_txn(16'h1234, 16'h4321, 1'b0, 17'h05555, 5, 1'b1, 16'h8000, 16'h8000, 1'b1);
    run_txn(16'h8000, 16'h8000, 1'b1, 17'h10001, 0, 1'b0, '0, '0, 1'b0);

    // Reset mid-RUN.
    @(negedge clk);
    bus.a = 16'hAAAA; bus.b = 16'h5555; bus.cin = 1'b1; bus.start_valid = 1'b1;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    chk("mid_busy", 64'(bus.busy), 64'd1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_sum",         64'(bus.sum),         64'd0);
    chk("mid_rst_done_valid",  64'(bus.done_valid),  64'd0);
    chk("mid_rst_busy",        64'(bus.busy),        64'd0);
    chk("mid_rst_start_ready", 64'(bus.start_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", 64'(bus.done_valid), 64'd0);
    end

    // WIDTH=4 instance.
    @(negedge clk);
    bus4.a = 4'hF; bus4.b = 4'h1; bus4.cin = 1'b1; bus4.start_valid = 1'b1;
    @(posedge clk); #1;
    bus4.start_valid = 1'b0;
    chk("w4_busy", 64'(bus4.busy), 64'd1);
    @(posedge clk); #1;
    chk("w4_done_valid", 64'(bus4.done_valid), 64'd1);
    chk("w4_sum",        64'(bus4.sum),        64'h11);
    bus4.done_ready = 1'b1;
    @(posedge clk); #1;
    bus4.done_ready = 1'b0;
    chk("w4_idle",     64'(bus4.start_ready), 64'd1);
    chk("w4_sum_kept", 64'(bus4.sum),         64'h11);

    // Random regression with random result stalls.
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rc   = 1'($urandom);
      rexp = {1'b0, ra} + {1'b0, rb} + (W+1)'(rc);
      run_txn(ra, rb, rc, rexp, int'($urandom_range(0, 4)), 1'b0, '0, '0, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
